bus_fabric: RTL

- Parametrised, registered successor to the combinational data-side decoder in the system top.
- Arbitrates NUM_MASTERS bus masters (core data port, DMA engine, debug) onto NUM_PERIPHERALS peripherals.
- Decodes addresses from base/mask parameters and supports slave wait states through a ready handshake.
- Returns an error response for unmapped addresses and for timed-out accesses.

---
 rtl/bus_fabric_if.sv | 51 +++++
 rtl/bus_fabric.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/bus_fabric_if.sv
// rtl/bus_fabric_if.sv - master-side and peripheral-side signal bundle for bus_fabric
//
// Purpose: groups the request/response signals of every bus master and the
// shared select/data signals of every peripheral into one interface.
// Ports (signals):
//   m_request/m_address/m_size/m_write_enable/m_write_data : per-master request
//   m_read_data/m_ready/m_error                             : per-master response
//   s_address/s_size/s_write_data                           : latched access to peripherals
//   s_read_enables/s_write_enables                          : one-hot peripheral selects
//   s_read_datas/s_ready                                    : per-peripheral response
// Modports: fabric (the arbiter/decoder), master (requesters), slave (peripherals).
interface bus_fabric_if #(
  parameter int NUM_MASTERS     = 2,
  parameter int NUM_PERIPHERALS = 4
);
  typedef logic [1:0] mem_size_t;

  logic [NUM_MASTERS-1:0]     m_request;
  logic [31:0]                m_address      [NUM_MASTERS];
  mem_size_t                  m_size         [NUM_MASTERS];
  logic [NUM_MASTERS-1:0]     m_write_enable;
  logic [31:0]                m_write_data   [NUM_MASTERS];
  logic [31:0]                m_read_data    [NUM_MASTERS];
  logic [NUM_MASTERS-1:0]     m_ready;
  logic [NUM_MASTERS-1:0]     m_error;

  logic [31:0]                s_address;
  mem_size_t                  s_size;
  logic [31:0]                s_write_data;
  logic [NUM_PERIPHERALS-1:0] s_read_enables;
  logic [NUM_PERIPHERALS-1:0] s_write_enables;
  logic [31:0]                s_read_datas   [NUM_PERIPHERALS];
  logic [NUM_PERIPHERALS-1:0] s_ready;

  modport fabric (
    input  m_request, m_address, m_size, m_write_enable, m_write_data,
    output m_read_data, m_ready, m_error,
    output s_address, s_size, s_write_data, s_read_enables, s_write_enables,
    input  s_read_datas, s_ready
  );

  modport master (
    output m_request, m_address, m_size, m_write_enable, m_write_data,
    input  m_read_data, m_ready, m_error
  );

  modport slave (
    input  s_address, s_size, s_write_data, s_read_enables, s_write_enables,
    output s_read_datas, s_ready
  );
endinterface

// File: rtl/bus_fabric.sv
// rtl/bus_fabric.sv - registered round-robin arbiter and address decoder for the data bus
//
// Purpose: grants one of NUM_MASTERS requesters at a time (round-robin), decodes
// its address against per-peripheral base/mask pairs, drives a one-hot enable
// to the selected peripheral until it answers with s_ready or the access times
// out, then returns a one-cycle m_ready (with m_error for miss/timeout).
// Ports:
//   clock   : system clock, rising edge
//   n_reset : asynchronous active-low reset
//   bus     : bus_fabric_if.fabric, all master and peripheral signals
module bus_fabric #(
  parameter int          NUM_MASTERS     = 2,
  parameter int          NUM_PERIPHERALS = 4,
  parameter logic [31:0] BASE_ADDRESSES [NUM_PERIPHERALS] =
    '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000},
  parameter logic [31:0] ADDRESS_MASKS  [NUM_PERIPHERALS] =
    '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000},
  parameter int          TIMEOUT_CYCLES  = 16
) (
  input  logic          clock,
  input  logic          n_reset,
  bus_fabric_if.fabric  bus
);
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int PW = (NUM_PERIPHERALS > 1) ? $clog2(NUM_PERIPHERALS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t         state;
  logic [MW-1:0]  rr_ptr;
  logic [MW-1:0]  grant;
  logic [PW-1:0]  sel;
  logic           wr;
  logic [TW-1:0]  timer;

  logic           req_found;
  logic [MW-1:0]  req_idx;
  logic [MW-1:0]  cand;
  logic           dec_hit;
  logic [PW-1:0]  dec_idx;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = MW'((int'(rr_ptr) + i) % NUM_MASTERS);
      if (!req_found && bus.m_request[cand]) begin
        req_found = 1'b1;
        req_idx   = cand;
      end
    end
  end

  // Scanning downwards lets the lowest matching index overwrite the others.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int j = NUM_PERIPHERALS - 1; j >= 0; j--) begin
      if ((bus.m_address[req_idx] & ADDRESS_MASKS[j]) == BASE_ADDRESSES[j]) begin
        dec_hit = 1'b1;
        dec_idx = PW'(j);
      end
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state               <= IDLE;
      rr_ptr              <= '0;
      grant               <= '0;
      sel                 <= '0;
      wr                  <= 1'b0;
      timer               <= '0;
      bus.m_ready         <= '0;
      bus.m_error         <= '0;
      bus.s_address       <= '0;
      bus.s_size          <= '0;
      bus.s_write_data    <= '0;
      bus.s_read_enables  <= '0;
      bus.s_write_enables <= '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        bus.m_read_data[i] <= '0;
      end
    end else begin
      // Response strobes are single-cycle by default.
      bus.m_ready <= '0;
      bus.m_error <= '0;
      case (state)
        IDLE: begin
          if (req_found) begin
            grant            <= req_idx;
            sel              <= dec_idx;
            wr               <= bus.m_write_enable[req_idx];
            bus.s_address    <= bus.m_address[req_idx];
            bus.s_size       <= bus.m_size[req_idx];
            bus.s_write_data <= bus.m_write_data[req_idx];
            if (dec_hit) begin
              state <= ACCESS;
              if (bus.m_write_enable[req_idx]) bus.s_write_enables[dec_idx] <= 1'b1;
              else                             bus.s_read_enables[dec_idx]  <= 1'b1;
            end else begin
              // Unmapped: answer straight away without touching any peripheral.
              state                    <= RESPOND;
              bus.m_ready[req_idx]     <= 1'b1;
              bus.m_error[req_idx]     <= 1'b1;
              bus.m_read_data[req_idx] <= '0;
            end
          end
        end
        ACCESS: begin
          timer <= timer + 1'b1;
          // A ready on the final counted cycle still completes successfully.
          if (bus.s_ready[sel]) begin
            state                  <= RESPOND;
            bus.s_read_enables     <= '0;
            bus.s_write_enables    <= '0;
            bus.m_ready[grant]     <= 1'b1;
            bus.m_read_data[grant] <= wr ? 32'h0 : bus.s_read_datas[sel];
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            state                  <= RESPOND;
            bus.s_read_enables     <= '0;
            bus.s_write_enables    <= '0;
            bus.m_ready[grant]     <= 1'b1;
            bus.m_error[grant]     <= 1'b1;
            bus.m_read_data[grant] <= '0;
          end
        end
        RESPOND: begin
          rr_ptr <= (grant == MW'(NUM_MASTERS - 1)) ? '0 : grant + 1'b1;
          timer  <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
